alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single ALU: IDLE -> ISSUE -> CAPTURE -> RESP.
// Define ALU_ARB_OVF_CNT_EN to build the saturating overflow counter on o_ovf_cnt.
module alu_arbiter (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid_0,
  input  logic [11:0] i_data_a_0,
  input  logic [11:0] i_data_b_0,
  input  logic [2:0]  i_inst_0,
  output logic        o_ready_0,
  input  logic        i_valid_1,
  input  logic [11:0] i_data_a_1,
  input  logic [11:0] i_data_b_1,
  input  logic [2:0]  i_inst_1,
  output logic        o_ready_1,
  output logic        o_alu_valid,
  output logic [11:0] o_alu_a,
  output logic [11:0] o_alu_b,
  output logic [2:0]  o_alu_inst,
  input  logic        i_alu_valid,
  input  logic [11:0] i_alu_data,
  input  logic        i_alu_overflow,
  output logic        o_resp_valid,
  output logic        o_resp_id,
  output logic [11:0] o_resp_data,
  output logic        o_resp_overflow,
  output logic        o_resp_err,
  input  logic        i_resp_ready,
  output logic [7:0]  o_ovf_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t      state_q, state_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic        id_q, id_d;
  logic        legal_q, legal_d;
  logic        alu_valid_q, alu_valid_d;
  logic [11:0] alu_a_q, alu_a_d;
  logic [11:0] alu_b_q, alu_b_d;
  logic [2:0]  alu_inst_q, alu_inst_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_id_q, resp_id_d;
  logic [11:0] resp_data_q, resp_data_d;
  logic        resp_ovf_q, resp_ovf_d;
  logic        resp_err_q, resp_err_d;

  logic [1:0]  req_valid;
  logic        grant;
  logic        xfer;
  logic [11:0] req_a, req_b;
  logic [2:0]  req_inst;
  logic        req_legal;

  function automatic logic is_legal(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b101);
  endfunction

  assign req_valid = {i_valid_1, i_valid_0};

  // The preferred requester wins; the other one only gets in when the preferred is idle.
  always_comb begin
    grant     = req_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
    xfer      = (state_q == IDLE) && req_valid[grant];
    o_ready_0 = xfer && !grant;
    o_ready_1 = xfer && grant;
    req_a     = grant ? i_data_a_1 : i_data_a_0;
    req_b     = grant ? i_data_b_1 : i_data_b_0;
    req_inst  = grant ? i_inst_1   : i_inst_0;
    req_legal = is_legal(req_inst);
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    legal_d      = legal_q;
    alu_valid_d  = 1'b0;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_inst_d   = alu_inst_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_ovf_d   = resp_ovf_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          id_d        = grant;
          legal_d     = req_legal;
          rr_ptr_d    = ~grant;
          alu_valid_d = req_legal;
          // Illegal ops never reach the ALU, so its operand bus keeps the last issued values.
          if (req_legal) begin
            alu_a_d    = req_a;
            alu_b_d    = req_b;
            alu_inst_d = req_inst;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        resp_valid_d = 1'b1;
        resp_id_d    = id_q;
        if (legal_q) begin
          resp_data_d = i_alu_data;
          resp_ovf_d  = i_alu_overflow;
          // The ALU drops valid on overflow, so either flag counts as a real answer.
          resp_err_d  = ~(i_alu_valid | i_alu_overflow);
        end else begin
          resp_data_d = '0;
          resp_ovf_d  = 1'b0;
          resp_err_d  = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (i_resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 1'b0;
      id_q         <= 1'b0;
      legal_q      <= 1'b0;
      alu_valid_q  <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_inst_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      resp_ovf_q   <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      legal_q      <= legal_d;
      alu_valid_q  <= alu_valid_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_inst_q   <= alu_inst_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_ovf_q   <= resp_ovf_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign o_alu_valid     = alu_valid_q;
  assign o_alu_a         = alu_a_q;
  assign o_alu_b         = alu_b_q;
  assign o_alu_inst      = alu_inst_q;
  assign o_resp_valid    = resp_valid_q;
  assign o_resp_id       = resp_id_q;
  assign o_resp_data     = resp_data_q;
  assign o_resp_overflow = resp_ovf_q;
  assign o_resp_err      = resp_err_q;

`ifdef ALU_ARB_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (resp_valid_q && i_resp_ready && resp_ovf_q && (ovf_cnt_q != 8'hFF))
      ovf_cnt_d = ovf_cnt_q + 8'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ovf_cnt_q <= '0;
    else          ovf_cnt_q <= ovf_cnt_d;
  end

  assign o_ovf_cnt = ovf_cnt_q;
`else
  assign o_ovf_cnt = '0;
`endif

endmodule
